// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for sync_fifo_param.
// The master modport belongs to the producer/consumer side, and the slave modport belongs to the FIFO.
interface sync_fifo_param_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic             flush;
    logic             wr;
    logic [WIDTH-1:0] din;
    logic             rd;
    logic [WIDTH-1:0] dout;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [AW:0]      count;
    logic             overflow;
    logic             underflow;
    logic             err_clr;

    modport master (
        output flush, wr, din, rd, err_clr,
        input  dout, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, wr, din, rd, err_clr,
        output dout, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered read data, occupancy count,
// programmable almost flags, synchronous flush and sticky overflow/underflow flags.
module sync_fifo_param #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input logic              clk,
    input logic              rst_n,
    sync_fifo_param_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_CNT   = (AW+1)'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic [WIDTH-1:0] dout;
    logic             rd_valid;
    logic             overflow;
    logic             underflow;
    logic             full;
    logic             empty;
    logic             rd_acc;
    logic             wr_acc;

    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_acc = bus.rd & ~empty;
    assign wr_acc = bus.wr & (~full | rd_acc);

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc && !bus.flush) begin
            mem[wptr] <= bus.din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            dout     <= '0;
            rd_valid <= 1'b0;
        end else if (bus.flush) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_acc) begin
                dout <= mem[rptr];
                rptr <= rptr + AW'(1);
            end
            rd_valid <= rd_acc;
            count    <= count + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
        end
    end

    // A new error in the same cycle as err_clr still sets the flag. Flush suppresses errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (!bus.flush && bus.wr && !wr_acc) begin
                overflow <= 1'b1;
            end else if (bus.err_clr) begin
                overflow <= 1'b0;
            end
            if (!bus.flush && bus.rd && !rd_acc) begin
                underflow <= 1'b1;
            end else if (bus.err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

    assign bus.dout         = dout;
    assign bus.rd_valid     = rd_valid;
    assign bus.count        = count;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count >= AF_CNT);
    assign bus.almost_empty = (count <= AE_CNT);
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param (WIDTH=8, DEPTH=16, AF=14, AE=2):
// accepted writes are queued and compared against dout on accepted reads.
module tb_sync_fifo_param;
    logic clk;
    logic rst_n;

    sync_fifo_param_if #(.WIDTH(8), .DEPTH(16)) bus ();

    sync_fifo_param #(
        .WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    // Reference model state
    logic [7:0] sb[$];
    int         m_count;
    logic [7:0] m_dout;
    logic       m_rdv;
    logic       m_ovf;
    logic       m_unf;
    logic       m_ra;
    logic       m_wa;

    function automatic logic [11:0] exp_status();
        logic [4:0] c;
        c = 5'(m_count);
        return {c == 5'd16, c == 5'd0, c >= 5'd14, c <= 5'd2, c, m_ovf, m_unf, m_rdv};
    endfunction

    function automatic logic [11:0] act_status();
        return {bus.full, bus.empty, bus.almost_full, bus.almost_empty, bus.count,
                bus.overflow, bus.underflow, bus.rd_valid};
    endfunction

    task automatic model_reset();
        sb.delete();
        m_count = 0;
        m_dout  = '0;
        m_rdv   = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    // One clock with the given inputs; updates the reference model from pre-edge state.
    task automatic drive(input logic w, input logic [7:0] d, input logic r,
                         input logic fl, input logic ec);
        bus.wr      = w;
        bus.din     = d;
        bus.rd      = r;
        bus.flush   = fl;
        bus.err_clr = ec;
        m_ra = r && (m_count != 0);
        m_wa = w && (m_count != 16 || m_ra);
        @(posedge clk);
        #1;
        if (fl) begin
            sb.delete();
            m_rdv = 1'b0;
            m_ra  = 1'b0;
            m_wa  = 1'b0;
            if (ec) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
        end else begin
            if (m_ra) m_dout = sb.pop_front();
            if (m_wa) sb.push_back(d);
            m_rdv = m_ra;
            if (w && !m_wa) m_ovf = 1'b1;
            else if (ec)    m_ovf = 1'b0;
            if (r && !m_ra) m_unf = 1'b1;
            else if (ec)    m_unf = 1'b0;
        end
        m_count     = sb.size();
        bus.wr      = 1'b0;
        bus.rd      = 1'b0;
        bus.flush   = 1'b0;
        bus.err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.wr = 1'b0; bus.rd = 1'b0; bus.flush = 1'b0; bus.err_clr = 1'b0; bus.din = '0;
        model_reset();
        #12;
        n_checks++;
        if (act_status() !== 12'b0101_00000_000) begin
            n_fail++;
            $display("FAIL reset_status: got %h exp %h", act_status(), 12'b0101_00000_000);
        end
        n_checks++;
        if (bus.dout !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_dout: got %h exp 00", bus.dout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 17; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (act_status() !== exp_status()) begin
                n_fail++;
                $display("FAIL fill_status[%0d]: got %h exp %h", i, act_status(), exp_status());
            end
        end
        n_checks++;
        if (bus.overflow !== 1'b1 || bus.count !== 5'd16) begin
            n_fail++;
            $display("FAIL overflow_17th: got ovf=%b cnt=%0d exp ovf=1 cnt=16", bus.overflow, bus.count);
        end
    endtask

    task automatic test_drain_underflow();
        for (int i = 1; i <= 17; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (act_status() !== exp_status()) begin
                n_fail++;
                $display("FAIL drain_status[%0d]: got %h exp %h", i, act_status(), exp_status());
            end
            if (m_rdv) begin
                n_checks++;
                if (bus.dout !== m_dout) begin
                    n_fail++;
                    $display("FAIL drain_dout[%0d]: got %h exp %h", i, bus.dout, m_dout);
                end
            end
        end
        n_checks++;
        if (bus.underflow !== 1'b1 || bus.dout !== 8'h10 || bus.rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL underflow_17th: got unf=%b dout=%h rdv=%b exp unf=1 dout=10 rdv=0",
                     bus.underflow, bus.dout, bus.rd_valid);
        end
    endtask

    task automatic test_full_rdwr();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 16; i++) drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (bus.dout !== 8'h01 || bus.count !== 5'd16 || bus.rd_valid !== 1'b1 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL full_rdwr: got dout=%h cnt=%0d rdv=%b ovf=%b exp dout=01 cnt=16 rdv=1 ovf=0",
                     bus.dout, bus.count, bus.rd_valid, bus.overflow);
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (bus.dout !== m_dout || act_status() !== exp_status()) begin
                n_fail++;
                $display("FAIL full_drain[%0d]: got dout=%h st=%h exp dout=%h st=%h",
                         i, bus.dout, act_status(), m_dout, exp_status());
            end
        end
        n_checks++;
        if (bus.dout !== 8'hAA) begin
            n_fail++;
            $display("FAIL full_last_word: got %h exp aa", bus.dout);
        end
    endtask

    task automatic test_empty_rdwr();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (bus.count !== 5'd1 || bus.rd_valid !== 1'b0 || bus.underflow !== 1'b1 || bus.empty !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_rdwr: got cnt=%0d rdv=%b unf=%b empty=%b exp cnt=1 rdv=0 unf=1 empty=0",
                     bus.count, bus.rd_valid, bus.underflow, bus.empty);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (bus.dout !== 8'h55 || bus.rd_valid !== 1'b1 || bus.count !== 5'd0) begin
            n_fail++;
            $display("FAIL empty_rdwr_read: got dout=%h rdv=%b cnt=%0d exp dout=55 rdv=1 cnt=0",
                     bus.dout, bus.rd_valid, bus.count);
        end
    endtask

    task automatic test_random_stream();
        int pushed = 0;
        int popped = 0;
        logic w, r;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int cyc = 0; cyc < 1000 && (pushed < 40 || popped < 40); cyc++) begin
            w = (pushed < 40) && ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 2) == 0) || (pushed >= 40);
            drive(w, 8'($urandom), r, 1'b0, 1'b0);
            if (m_wa) pushed++;
            if (m_ra) popped++;
            n_checks++;
            if (act_status() !== exp_status()) begin
                n_fail++;
                $display("FAIL rand_status[%0d]: got %h exp %h", cyc, act_status(), exp_status());
            end
            if (m_rdv) begin
                n_checks++;
                if (bus.dout !== m_dout) begin
                    n_fail++;
                    $display("FAIL rand_dout[%0d]: got %h exp %h", cyc, bus.dout, m_dout);
                end
            end
        end
        n_checks++;
        if (popped != 40) begin
            n_fail++;
            $display("FAIL rand_timeout: got %0d reads exp 40", popped);
        end
    endtask

    task automatic test_flush_reset();
        logic [7:0] held;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
        held = m_dout;
        drive(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.overflow !== 1'b0 || bus.rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush: got cnt=%0d empty=%b ovf=%b rdv=%b exp cnt=0 empty=1 ovf=0 rdv=0",
                     bus.count, bus.empty, bus.overflow, bus.rd_valid);
        end
        n_checks++;
        if (bus.dout !== held) begin
            n_fail++;
            $display("FAIL flush_dout_hold: got %h exp %h", bus.dout, held);
        end
        drive(1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h62, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'h63, 1'b1, 1'b0, 1'b0);
        bus.wr = 1'b1;
        bus.rd = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (act_status() !== 12'b0101_00000_000 || bus.dout !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: got st=%h dout=%h exp st=%h dout=00",
                     act_status(), bus.dout, 12'b0101_00000_000);
        end
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (act_status() !== exp_status()) begin
            n_fail++;
            $display("FAIL post_reset_empty: got %h exp %h", act_status(), exp_status());
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_full_rdwr();
        test_empty_rdwr();
        test_random_stream();
        test_flush_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
